// File: rtl/riscv_lsu.sv
// Load/store unit: one valid/ready request plus one response beat per access on a 64-bit bus.
// Optional LSU_MISALIGN_TRAP_EN: misaligned accesses are trapped instead of being force-aligned.
module riscv_lsu #(
    parameter int XLEN   = 64,
    parameter int STRB_W = XLEN / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   addr,
    input  logic [XLEN-1:0]   wdata,
    output logic              lsu_stall,
    output logic [XLEN-1:0]   load_data,
    output logic              misalign_err,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_we,
    output logic [XLEN-1:0]   req_addr,
    output logic [STRB_W-1:0] req_wstrb,
    output logic [XLEN-1:0]   req_wdata,
    input  logic              rsp_valid,
    input  logic [XLEN-1:0]   rsp_rdata
);
    localparam int OFF_W = $clog2(STRB_W);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t            state;
    logic [2:0]        f3_q;
    logic [OFF_W-1:0]  off_q;
    logic              mis_q;

    logic [OFF_W-1:0]  off_raw, off_nat, off_mask;
    logic [STRB_W-1:0] strb_base, strb;
    logic [XLEN-1:0]   wdata_sh, rsp_sh, ld_ext;
    logic              mis;
    logic              start;

    assign start   = mem_read | mem_write;
    assign off_raw = addr[OFF_W-1:0];

    // funct3[1:0] encodes the access size for both loads and stores; 111 falls into the D case.
    always_comb begin
        off_mask  = '0;
        strb_base = '0;
        case (funct3[1:0])
            2'b00: begin off_mask = '0;           strb_base = STRB_W'(8'h01); end
            2'b01: begin off_mask = OFF_W'(1);    strb_base = STRB_W'(8'h03); end
            2'b10: begin off_mask = OFF_W'(3);    strb_base = STRB_W'(8'h0F); end
            default: begin off_mask = '1;         strb_base = '1;             end
        endcase
        off_nat  = off_raw & ~off_mask;
        strb     = strb_base << off_nat;
        wdata_sh = wdata << {off_nat, 3'b000};
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign mis = (off_raw & off_mask) != '0;
`else
    assign mis = 1'b0;
`endif

    always_comb begin
        rsp_sh = rsp_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  ld_ext = {{(XLEN-8){rsp_sh[7]}},   rsp_sh[7:0]};
            3'b001:  ld_ext = {{(XLEN-16){rsp_sh[15]}}, rsp_sh[15:0]};
            3'b010:  ld_ext = {{(XLEN-32){rsp_sh[31]}}, rsp_sh[31:0]};
            3'b100:  ld_ext = {{(XLEN-8){1'b0}},        rsp_sh[7:0]};
            3'b101:  ld_ext = {{(XLEN-16){1'b0}},       rsp_sh[15:0]};
            3'b110:  ld_ext = {{(XLEN-32){1'b0}},       rsp_sh[31:0]};
            default: ld_ext = rsp_sh;
        endcase
    end

    assign lsu_stall    = ((state == IDLE) && start) || (state == REQ) || (state == WAIT);
    assign misalign_err = mis_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            f3_q      <= '0;
            off_q     <= '0;
            mis_q     <= 1'b0;
            req_valid <= 1'b0;
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wstrb <= '0;
            req_wdata <= '0;
            load_data <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    if (mis) begin
                        // Trapped access never reaches the bus.
                        mis_q     <= 1'b1;
                        load_data <= '0;
                        state     <= DONE;
                    end else begin
                        f3_q      <= funct3;
                        off_q     <= off_nat;
                        req_we    <= mem_write;
                        req_addr  <= {addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
                        req_wstrb <= mem_write ? strb : '0;
                        req_wdata <= mem_write ? wdata_sh : '0;
                        req_valid <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: if (req_ready) begin
                    req_valid <= 1'b0;
                    state     <= WAIT;
                end
                WAIT: if (rsp_valid) begin
                    if (!req_we) load_data <= ld_ext;
                    state <= DONE;
                end
                default: begin
                    mis_q <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu: directed table, hand-written corner sequences and randomized accesses
// checked against an arithmetic reference model.
module tb_riscv_lsu;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [63:0] addr, wdata;
    logic        lsu_stall;
    logic [63:0] load_data;
    logic        misalign_err;
    logic        req_valid, req_ready, req_we;
    logic [63:0] req_addr;
    logic [7:0]  req_wstrb;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;

    int total = 0;
    int bad   = 0;

    riscv_lsu dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .wdata(wdata), .lsu_stall(lsu_stall),
        .load_data(load_data), .misalign_err(misalign_err), .req_valid(req_valid),
        .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr), .req_wstrb(req_wstrb),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // Reference model: byte-level arithmetic straight from the access rules.
    function automatic void model(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd,
                                  input logic [63:0] rdat, output logic [63:0] e_addr,
                                  output logic [7:0] e_strb, output logic [63:0] e_wdata,
                                  output logic [63:0] e_load, output bit e_mis);
        int n, ro, o;
        logic [63:0] r, mask, v;
        n      = 1 << f3[1:0];
        ro     = int'(a % 64'd8);
        o      = (ro / n) * n;
        e_mis  = TRAP && (ro % n != 0);
        e_addr = a - 64'(ro);
        e_strb = 8'(((1 << n) - 1) << o);
        e_wdata = wd << (8 * o);
        r = rdat >> (8 * o);
        if (n == 8) e_load = r;
        else begin
            mask = (64'd1 << (8 * n)) - 64'd1;
            v = r & mask;
            if (!f3[2] && r[8*n-1]) v = v | ~mask;
            e_load = v;
        end
    endfunction

    // Runs one access; all driving and sampling happens on the falling edge.
    task automatic run_txn(input bit rd, input bit wr, input logic [2:0] f3, input logic [63:0] a,
                           input logic [63:0] wd, input logic [63:0] rdat, input int rdy_dly,
                           input int rsp_dly, input logic [63:0] e_addr, input logic [7:0] e_strb,
                           input logic [63:0] e_wdata, input logic [63:0] e_load, input bit e_mis);
        int stalls;
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
        #1;
        chk("stall_idle", 64'(lsu_stall), 64'd1);
        stalls = 1;
        @(posedge clk); @(negedge clk);
        if (e_mis) begin
            chk("mis_err", 64'(misalign_err), 64'd1);
            chk("mis_novalid", 64'(req_valid), 64'd0);
            chk("mis_stall", 64'(lsu_stall), 64'd0);
            chk("mis_load", load_data, 64'd0);
            mem_read = 1'b0; mem_write = 1'b0;
            @(posedge clk); @(negedge clk);
            chk("mis_err_clr", 64'(misalign_err), 64'd0);
            return;
        end
        for (int i = 0; i <= rdy_dly; i++) begin
            chk("req_valid", 64'(req_valid), 64'd1);
            chk("req_addr", req_addr, e_addr);
            chk("req_we", 64'(req_we), 64'(wr));
            chk("req_wstrb", 64'(req_wstrb), wr ? 64'(e_strb) : 64'd0);
            if (wr) chk("req_wdata", req_wdata, e_wdata);
            stalls += int'(lsu_stall);
            req_ready = (i == rdy_dly);
            @(posedge clk); @(negedge clk);
        end
        req_ready = 1'b0;
        chk("valid_drop", 64'(req_valid), 64'd0);
        for (int i = 0; i < rsp_dly; i++) begin
            stalls += int'(lsu_stall);
            rsp_valid = (i == rsp_dly - 1);
            rsp_rdata = rsp_valid ? rdat : {$urandom, $urandom};
            @(posedge clk); @(negedge clk);
        end
        rsp_valid = 1'b0;
        chk("done_stall", 64'(lsu_stall), 64'd0);
        chk("stall_cycles", 64'(stalls), 64'(rdy_dly + 2 + rsp_dly));
        chk("done_mis", 64'(misalign_err), 64'd0);
        if (!wr) chk("load_data", load_data, e_load);
        mem_read = 1'b0; mem_write = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("idle_after", 64'(lsu_stall | req_valid), 64'd0);
    endtask

    typedef struct {
        bit          rd, wr;
        logic [2:0]  f3;
        logic [63:0] a, wd, rdat;
        logic [63:0] e_addr;
        logic [7:0]  e_strb;
        logic [63:0] e_wdata, e_load;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [63:0] ea, ew, el, a, wd, rdat;
        logic [7:0]  es;
        bit          em, rd, wr;
        logic [2:0]  f3;
        int          k;

        vecs[0] = '{0, 1, 3'b010, 64'h1004, 64'hDEADBEEF, 64'h0, 64'h1000, 8'hF0, 64'hDEADBEEF_00000000, 64'h0};
        vecs[1] = '{1, 0, 3'b000, 64'h2003, 64'h0, 64'h00000000_80000000, 64'h2000, 8'h00, 64'h0, 64'hFFFFFFFF_FFFFFF80};
        vecs[2] = '{1, 0, 3'b100, 64'h2003, 64'h0, 64'h00000000_80000000, 64'h2000, 8'h00, 64'h0, 64'h80};
        vecs[3] = '{1, 1, 3'b011, 64'h10, 64'h01234567_89ABCDEF, 64'h0, 64'h10, 8'hFF, 64'h01234567_89ABCDEF, 64'h0};
        vecs[4] = '{1, 0, 3'b001, 64'h2006, 64'h0, 64'h80010000_00000000, 64'h2000, 8'h00, 64'h0, 64'hFFFFFFFF_FFFF8001};
        vecs[5] = '{1, 0, 3'b101, 64'h2006, 64'h0, 64'h80010000_00000000, 64'h2000, 8'h00, 64'h0, 64'h8001};
        vecs[6] = '{1, 0, 3'b110, 64'h2004, 64'h0, 64'hF0000000_00000000, 64'h2000, 8'h00, 64'h0, 64'hF0000000};
        vecs[7] = '{1, 0, 3'b010, 64'h2004, 64'h0, 64'hF0000000_00000000, 64'h2000, 8'h00, 64'h0, 64'hFFFFFFFF_F0000000};
        vecs[8] = '{0, 1, 3'b000, 64'h1007, 64'hAB, 64'h0, 64'h1000, 8'h80, 64'hAB000000_00000000, 64'h0};
        vecs[9] = '{1, 0, 3'b111, 64'h18, 64'h0, 64'h11223344_55667788, 64'h18, 8'h00, 64'h0, 64'h11223344_55667788};

        rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b0; addr = '0; wdata = '0;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0;
        @(negedge clk); @(negedge clk);
        chk("rst_valid", 64'(req_valid), 64'd0);
        chk("rst_we", 64'(req_we), 64'd0);
        chk("rst_stall", 64'(lsu_stall), 64'd0);
        chk("rst_mis", 64'(misalign_err), 64'd0);
        chk("rst_addr", req_addr, 64'd0);
        chk("rst_strb", 64'(req_wstrb), 64'd0);
        chk("rst_wdata", req_wdata, 64'd0);
        chk("rst_load", load_data, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_no_req", 64'(lsu_stall | req_valid), 64'd0);

        foreach (vecs[i])
            run_txn(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].a, vecs[i].wd, vecs[i].rdat, 0, 1,
                    vecs[i].e_addr, vecs[i].e_strb, vecs[i].e_wdata, vecs[i].e_load, 1'b0);

        // LD with a slow accept and a late response
        run_txn(1, 0, 3'b011, 64'h4008, 64'h0, 64'hCAFEF00D_12345678, 4, 2,
                64'h4008, 8'h00, 64'h0, 64'hCAFEF00D_12345678, 1'b0);

        // Reset pulsed while waiting for the response
        mem_read = 1'b1; funct3 = 3'b011; addr = 64'h5000;
        @(posedge clk); @(negedge clk);
        req_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        req_ready = 1'b0;
        chk("pre_rst_wait_stall", 64'(lsu_stall), 64'd1);
        rst_n = 1'b0; mem_read = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(req_valid), 64'd0);
        chk("rst_mid_stall", 64'(lsu_stall), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_valid = 1'b1; rsp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk); @(negedge clk);
        rsp_valid = 1'b0;
        chk("stale_rsp_stall", 64'(lsu_stall), 64'd0);
        chk("stale_rsp_load", load_data, 64'd0);
        run_txn(1, 0, 3'b010, 64'h5004, 64'h0, 64'h7654_3210_0000_0000, 0, 1,
                64'h5000, 8'h00, 64'h0, 64'h76543210, 1'b0);

        // Misaligned halfword accesses
        if (TRAP) begin
            run_txn(1, 0, 3'b001, 64'h3001, 64'h0, 64'h0, 0, 1, 64'h0, 8'h0, 64'h0, 64'h0, 1'b1);
            run_txn(0, 1, 3'b001, 64'h3001, 64'hBEEF, 64'h0, 0, 1, 64'h0, 8'h0, 64'h0, 64'h0, 1'b1);
        end else begin
            run_txn(1, 0, 3'b001, 64'h3001, 64'h0, 64'h11223344_5566A0B1, 0, 1,
                    64'h3000, 8'h00, 64'h0, 64'hFFFFFFFF_FFFFA0B1, 1'b0);
            run_txn(0, 1, 3'b001, 64'h3001, 64'hBEEF, 64'h0, 0, 1,
                    64'h3000, 8'h03, 64'hBEEF, 64'h0, 1'b0);
        end

        for (int t = 0; t < 60; t++) begin
            k    = int'($urandom_range(0, 2));
            rd   = (k != 1);
            wr   = (k != 0);
            f3   = 3'($urandom_range(0, 7));
            a    = {$urandom, $urandom};
            wd   = {$urandom, $urandom};
            rdat = {$urandom, $urandom};
            model(f3, a, wd, rdat, ea, es, ew, el, em);
            run_txn(rd, wr, f3, a, wd, rdat, int'($urandom_range(0, 2)), int'($urandom_range(1, 3)),
                    ea, es, ew, el, em);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
